regfile_mc: RTL and testbench

- Parametrised, clocked register file for the multicycle processor.
- Replaces the per-register slot modules with a single array that has:
  - two read ports (rs/rt) feeding the A/B operand latches;
  - one write port (rd).
- Adds write enable, a hard-wired zero register, optional write-through bypass, and a serial clear sequencer that runs after reset.
- Sits between instruction decode (addresses) and the ALU operand registers.

---
 rtl/regfile_mc.sv | 148 ++++++++++++++
 tb/tb_regfile_mc.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mc.sv
// ---------------------------------------------------------------------------
// regfile_mc -- register file for the multicycle processor.
//
// One array of NREGS = 2**ADDR_W registers with two registered read ports
// (rs -> out_data_a, rt -> out_data_b) and one write port (rd).
// Features:
//   - a hard-wired zero register;
//   - optional write-through bypass;
//   - after reset, an optional serial clear sequencer that zeroes one
//     register per cycle while busy is high.
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   rs, rt       read addresses for port A / port B
//   rd           write address
//   i_data       write data
//   we           write enable
//   rd_en        read-latch enable, loads out_data_a / out_data_b
//   out_data_a   registered read data, port A
//   out_data_b   registered read data, port B
//   busy         clear sequence in progress
//   dbg_state_o  current sequencer state (0 = IDLE, 1 = CLEAR)
//
// Access contract:
// - A write (we) and a read (rd_en) are each accepted at a rising edge only
//   when busy is low.
// - An accepted read presents its data on out_data_a/out_data_b after that
//   same edge (1-cycle latency).
// - The outputs then hold until the next accepted read or reset.
// - While busy is high, we and rd_en are ignored and both outputs stay 0.
// ---------------------------------------------------------------------------
module regfile_mc #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int ZERO_REG     = 1,
    parameter int BYPASS       = 1,
    parameter int SERIAL_CLEAR = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] i_data,
    input  logic              we,
    input  logic              rd_en,
    output logic [DATA_W-1:0] out_data_a,
    output logic [DATA_W-1:0] out_data_b,
    output logic              busy,
    output logic              dbg_state_o
);

    localparam int NREGS = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [DATA_W-1:0] mem_q [NREGS];
    logic [DATA_W-1:0] out_a_q;
    logic [DATA_W-1:0] out_b_q;

    logic              wr_ok;
    logic [DATA_W-1:0] rd_a_d;
    logic [DATA_W-1:0] rd_b_d;

    // A write to register 0 is dropped when it is hard-wired to zero; the
    // bypass must not forward a dropped write either.
    always_comb begin
        wr_ok = we;
        if (ZERO_REG != 0 && rd == '0) begin
            wr_ok = 1'b0;
        end
    end

    // Read value selection: zero register beats bypass beats array contents.
    // The array term is the pre-write contents of the current cycle.
    always_comb begin
        rd_a_d = mem_q[rs];
        if (BYPASS != 0 && wr_ok && rd == rs) begin
            rd_a_d = i_data;
        end
        if (ZERO_REG != 0 && rs == '0) begin
            rd_a_d = '0;
        end

        rd_b_d = mem_q[rt];
        if (BYPASS != 0 && wr_ok && rd == rt) begin
            rd_b_d = i_data;
        end
        if (ZERO_REG != 0 && rt == '0) begin
            rd_b_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_a_q <= '0;
            out_b_q <= '0;
            ptr_q   <= '0;
            if (SERIAL_CLEAR != 0) begin
                state_q <= ST_CLEAR;
            end else begin
                state_q <= ST_IDLE;
                for (int i = 0; i < NREGS; i++) begin
                    mem_q[i] <= '0;
                end
            end
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    // One register per cycle.
                    // Leaving on the last index gives exactly NREGS busy cycles.
                    mem_q[ptr_q] <= '0;
                    ptr_q        <= ptr_q + 1'b1;
                    out_a_q      <= '0;
                    out_b_q      <= '0;
                    if (ptr_q == LAST_IDX) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (wr_ok) begin
                        mem_q[rd] <= i_data;
                    end
                    if (rd_en) begin
                        out_a_q <= rd_a_d;
                        out_b_q <= rd_b_d;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_data_a  = out_a_q;
    assign out_data_b  = out_b_q;
    assign busy        = (state_q == ST_CLEAR);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_regfile_mc.sv
// ---------------------------------------------------------------------------
// tb_regfile_mc -- randomized scoreboard bench for regfile_mc.
//
// Two instances share one stimulus stream:
//   u_dflt -- default parameters;
//   u_alt  -- ZERO_REG=0, BYPASS=0, SERIAL_CLEAR=0.
//
// Each instance has its own behavioural model:
//   - a plain array of register values;
//   - a count of remaining clear cycles;
//   - the two output values.
//
// Every driven cycle pushes the expected {busy, a, b} into a per-instance
// queue; a monitor pops one entry after every rising edge and compares.
// ---------------------------------------------------------------------------
module tb_regfile_mc;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;
  localparam int EW = 1 + 2 * DW;

  logic          clk;
  logic          rst;
  logic [AW-1:0] rs, rt, rd;
  logic [DW-1:0] i_data;
  logic          we, rd_en;

  logic [DW-1:0] a0, b0, a1, b1;
  logic          busy0, busy1, st0, st1;

  regfile_mc u_dflt (
    .clk(clk), .rst(rst), .rs(rs), .rt(rt), .rd(rd), .i_data(i_data),
    .we(we), .rd_en(rd_en), .out_data_a(a0), .out_data_b(b0),
    .busy(busy0), .dbg_state_o(st0)
  );

  regfile_mc #(.ZERO_REG(0), .BYPASS(0), .SERIAL_CLEAR(0)) u_alt (
    .clk(clk), .rst(rst), .rs(rs), .rt(rt), .rd(rd), .i_data(i_data),
    .we(we), .rd_en(rd_en), .out_data_a(a1), .out_data_b(b1),
    .busy(busy1), .dbg_state_o(st1)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  logic [DW-1:0] m_regs [2][NR];
  int            m_clear [2];
  logic [DW-1:0] m_a [2];
  logic [DW-1:0] m_b [2];

  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];
  string         tag_q0[$];
  string         tag_q1[$];

  int vectors;
  int miscompares;

  function automatic logic [DW-1:0] m_val(int k, bit zr, bit byp, int x);
    if (zr && x == 0) return '0;
    if (byp && we && int'(rd) == x && !(zr && rd == '0)) return i_data;
    return m_regs[k][x];
  endfunction

  function automatic void m_step(int k, bit zr, bit byp, bit sc);
    logic [DW-1:0] va, vb;
    if (rst) begin
      m_a[k] = '0;
      m_b[k] = '0;
      m_clear[k] = sc ? NR : 0;
      // Nothing can observe or modify the array until the clear finishes,
      // so the model zeroes it all at once.
      for (int i = 0; i < NR; i++) m_regs[k][i] = '0;
    end else if (m_clear[k] > 0) begin
      m_clear[k]--;
    end else begin
      va = m_val(k, zr, byp, int'(rs));
      vb = m_val(k, zr, byp, int'(rt));
      if (rd_en) begin
        m_a[k] = va;
        m_b[k] = vb;
      end
      if (we && !(zr && rd == '0)) m_regs[k][int'(rd)] = i_data;
    end
  endfunction

  // ---------------- driver ----------------
  task automatic step(input string tag, input bit r, input bit w, input int wa,
                      input logic [DW-1:0] d, input bit re, input int ra, input int rb);
    @(negedge clk);
    rst    = r;
    we     = w;
    rd     = AW'(wa);
    i_data = d;
    rd_en  = re;
    rs     = AW'(ra);
    rt     = AW'(rb);
    m_step(0, 1'b1, 1'b1, 1'b1);
    m_step(1, 1'b0, 1'b0, 1'b0);
    exp_q0.push_back({m_clear[0] > 0, m_a[0], m_b[0]});
    exp_q1.push_back({m_clear[1] > 0, m_a[1], m_b[1]});
    tag_q0.push_back(tag);
    tag_q1.push_back(tag);
  endtask

  function automatic int rand_addr();
    // Bias toward a few low addresses so collisions and r0 are frequent.
    if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 3));
    return int'($urandom_range(0, NR - 1));
  endfunction

  task automatic rand_step(input string tag, input bit allow_rst);
    bit r;
    r = allow_rst && ($urandom_range(0, 149) == 0);
    step(tag, r, $urandom_range(0, 1) == 1, rand_addr(), $urandom,
         $urandom_range(0, 2) != 0, rand_addr(), rand_addr());
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [EW-1:0] e, g;
    string t;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q0.size() > 0) begin
        e = exp_q0.pop_front();
        t = tag_q0.pop_front();
        g = {busy0, a0, b0};
        vectors++;
        if (g !== e) begin
          miscompares++;
          $display("FAIL dflt %s: got busy=%b a=%h b=%h, expected busy=%b a=%h b=%h",
                   t, g[EW-1], g[2*DW-1:DW], g[DW-1:0], e[EW-1], e[2*DW-1:DW], e[DW-1:0]);
        end
      end
      if (exp_q1.size() > 0) begin
        e = exp_q1.pop_front();
        t = tag_q1.pop_front();
        g = {busy1, a1, b1};
        vectors++;
        if (g !== e) begin
          miscompares++;
          $display("FAIL alt %s: got busy=%b a=%h b=%h, expected busy=%b a=%h b=%h",
                   t, g[EW-1], g[2*DW-1:DW], g[DW-1:0], e[EW-1], e[2*DW-1:DW], e[DW-1:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1; we = 1'b0; rd_en = 1'b0;
    rs = '0; rt = '0; rd = '0; i_data = '0;

    // Serial clear with a write and a read attempted while busy.
    step("reset", 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < NR; i++)
      step("clear", 0, i == 3, 5, 32'hDEADBEEF, i == 10, 5, 5);
    step("read_r5", 0, 0, 0, 0, 1, 5, 5);

    // Write then read.
    step("wr_r7", 0, 1, 7, 32'h12345678, 0, 0, 0);
    step("rd_r7", 0, 0, 0, 0, 1, 7, 7);

    // Bypass versus old value.
    step("wr_r3", 0, 1, 3, 32'h00000001, 0, 0, 0);
    step("bypass", 0, 1, 3, 32'hA5A5A5A5, 1, 3, 7);
    step("reread_r3", 0, 0, 0, 0, 1, 3, 3);

    // Zero register.
    step("zero_wr", 0, 1, 0, 32'hFFFFFFFF, 1, 0, 0);
    step("zero_reread", 0, 0, 0, 0, 1, 0, 3);

    // Dual port and hold.
    step("wr_r1", 0, 1, 1, 32'h11, 0, 0, 0);
    step("wr_r2", 0, 1, 2, 32'h22, 0, 0, 0);
    step("rd_r1_r2", 0, 0, 0, 0, 1, 1, 2);
    for (int i = 0; i < 3; i++)
      step("hold", 0, 0, 0, 0, 0, rand_addr(), rand_addr());

    // Fill the array, then reset and reassert reset mid-clear.
    for (int i = 0; i < NR; i++)
      step("fill", 0, 1, i, $urandom, 0, 0, 0);
    step("reset2", 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) rand_step("midclear", 0);
    step("reset3", 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < NR; i++) rand_step("reclear", 0);
    for (int i = 0; i < NR / 2; i++)
      step("post_clear_rd", 0, 0, 0, 0, 1, 2 * i, 2 * i + 1);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 600; i++) rand_step("random", 1);

    // Drain the scoreboard.
    @(posedge clk);
    #2;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d/%0d entries left, expected 0/0", exp_q0.size(), exp_q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
